uart_controller: RTL and testbench

- Data-bus slave for the UART window; the data_bus decoder routes UART-region accesses here.
- Holds a TX FIFO feeding an 8N1 serializer on txd, and an RX deserializer on rxd feeding an RX FIFO.
- Single-cycle register access; the CPU is never stalled.
- Baud timing is derived from a fixed clocks-per-bit divider.

---
 rtl/uart_controller_if.sv | 20 ++
 rtl/uart_controller.sv | 257 +++++++++++++++++++++++++
 tb/tb_uart_controller.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_controller_if.sv
// Data-bus connection for the UART window: strobes, address, byte mask and read-back data.
interface uart_controller_if;
    logic        bus_read;
    logic        bus_write;
    logic [31:0] bus_address;
    logic [31:0] bus_data_wr;
    logic [3:0]  bus_mask;
    logic [31:0] bus_data_rd;
    logic        bus_stall;

    modport master (
        output bus_read, bus_write, bus_address, bus_data_wr, bus_mask,
        input  bus_data_rd, bus_stall
    );

    modport slave (
        input  bus_read, bus_write, bus_address, bus_data_wr, bus_mask,
        output bus_data_rd, bus_stall
    );
endinterface

// File: rtl/uart_controller.sv
// UART data-bus slave: TX FIFO into an 8N1 serializer, RX deserializer into an RX FIFO.
// Define UART_LOOPBACK_EN to route the internal TX line into the receiver and hold txd high.
module uart_controller #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    uart_controller_if.slave   bus,
    output logic               txd,
    input  logic               rxd
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BAUD_HALF = BW'(CLKS_PER_BIT / 2 - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic [1:0]    w_sel;
    logic          w_dataRead;
    logic          w_statusRead;
    logic          w_dataWrite;
    logic [31:0]   w_status;
    logic [31:0]   w_rdData;
    logic          w_loopFlag;
    logic          w_rxIn;
    logic          w_unusedPins;
    logic          w_unused;

    logic [7:0]    r_txMem [FIFO_DEPTH];
    logic [AW:0]   r_txWrPtr;
    logic [AW:0]   r_txRdPtr;
    logic          w_txEmpty;
    logic          w_txFull;
    logic          w_txPush;
    logic          w_txPop;
    logic          w_txIdle;

    logic [1:0]    r_txState;
    logic [BW-1:0] r_txBaud;
    logic [2:0]    r_txBitIdx;
    logic [7:0]    r_txShift;
    logic          r_txLine;

    logic [7:0]    r_rxMem [FIFO_DEPTH];
    logic [AW:0]   r_rxWrPtr;
    logic [AW:0]   r_rxRdPtr;
    logic          w_rxEmpty;
    logic          w_rxFull;
    logic          w_rxPush;
    logic          w_rxPop;

    logic          r_rxSync1;
    logic          r_rxSync2;
    logic          w_rxFall;
    logic [1:0]    r_rxState;
    logic [BW-1:0] r_rxBaud;
    logic [2:0]    r_rxBitIdx;
    logic [7:0]    r_rxShift;
    logic          w_rxStopSample;
    logic          w_overrunSet;
    logic          w_frameErrSet;
    logic          r_overrun;
    logic          r_frameErr;

`ifdef UART_LOOPBACK_EN
    assign w_rxIn       = r_txLine;
    assign txd          = 1'b1;
    assign w_loopFlag   = 1'b1;
    assign w_unusedPins = rxd;
`else
    assign w_rxIn       = rxd;
    assign txd          = r_txLine;
    assign w_loopFlag   = 1'b0;
    assign w_unusedPins = 1'b0;
`endif

    assign w_unused = &{1'b0, w_unusedPins, bus.bus_address[31:4], bus.bus_address[1:0],
                        bus.bus_data_wr[31:8], bus.bus_mask[3:1]};

    assign w_sel        = bus.bus_address[3:2];
    assign w_dataRead   = bus.bus_read  && (w_sel == 2'd0);
    assign w_statusRead = bus.bus_read  && (w_sel == 2'd1);
    assign w_dataWrite  = bus.bus_write && (w_sel == 2'd0) && bus.bus_mask[0];

    assign w_txEmpty = (r_txWrPtr == r_txRdPtr);
    assign w_txFull  = (r_txWrPtr[AW] != r_txRdPtr[AW]) && (r_txWrPtr[AW-1:0] == r_txRdPtr[AW-1:0]);
    assign w_txPush  = w_dataWrite && !w_txFull;
    assign w_txPop   = (r_txState == S_IDLE) && !w_txEmpty;
    assign w_txIdle  = w_txEmpty && (r_txState == S_IDLE);

    assign w_rxEmpty = (r_rxWrPtr == r_rxRdPtr);
    assign w_rxFull  = (r_rxWrPtr[AW] != r_rxRdPtr[AW]) && (r_rxWrPtr[AW-1:0] == r_rxRdPtr[AW-1:0]);
    assign w_rxPop   = w_dataRead && !w_rxEmpty;

    assign w_rxFall       = r_rxSync2 && !r_rxSync1;
    assign w_rxStopSample = (r_rxState == S_STOP) && (r_rxBaud == BAUD_LAST);
    assign w_rxPush       = w_rxStopSample && r_rxSync2 && !w_rxFull;
    assign w_overrunSet   = w_rxStopSample && r_rxSync2 && w_rxFull;
    assign w_frameErrSet  = w_rxStopSample && !r_rxSync2;

    assign w_status = {w_loopFlag, 26'h0, r_frameErr, r_overrun, !w_rxEmpty, w_txIdle, w_txFull};

    always_comb begin
        w_rdData = 32'h0;
        if (bus.bus_read) begin
            case (w_sel)
                2'd0:    if (!w_rxEmpty) w_rdData = {24'h0, r_rxMem[r_rxRdPtr[AW-1:0]]};
                2'd1:    w_rdData = w_status;
                default: w_rdData = 32'h0;
            endcase
        end
    end

    assign bus.bus_data_rd = w_rdData;
    assign bus.bus_stall   = 1'b0;

    // FIFO storage carries no reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (w_txPush) r_txMem[r_txWrPtr[AW-1:0]] <= bus.bus_data_wr[7:0];
        if (w_rxPush) r_rxMem[r_rxWrPtr[AW-1:0]] <= r_rxShift;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_txWrPtr <= '0;
            r_txRdPtr <= '0;
            r_rxWrPtr <= '0;
            r_rxRdPtr <= '0;
        end else begin
            if (w_txPush) r_txWrPtr <= r_txWrPtr + (AW+1)'(1);
            if (w_txPop)  r_txRdPtr <= r_txRdPtr + (AW+1)'(1);
            if (w_rxPush) r_rxWrPtr <= r_rxWrPtr + (AW+1)'(1);
            if (w_rxPop)  r_rxRdPtr <= r_rxRdPtr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overrun  <= 1'b0;
            r_frameErr <= 1'b0;
        end else begin
            r_overrun  <= w_overrunSet  || (r_overrun  && !w_statusRead);
            r_frameErr <= w_frameErrSet || (r_frameErr && !w_statusRead);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_txState  <= S_IDLE;
            r_txBaud   <= '0;
            r_txBitIdx <= '0;
            r_txShift  <= '0;
            r_txLine   <= 1'b1;
        end else begin
            case (r_txState)
                S_IDLE: begin
                    if (w_txPop) begin
                        r_txShift <= r_txMem[r_txRdPtr[AW-1:0]];
                        r_txLine  <= 1'b0;
                        r_txBaud  <= '0;
                        r_txState <= S_START;
                    end
                end
                S_START: begin
                    if (r_txBaud == BAUD_LAST) begin
                        r_txBaud   <= '0;
                        r_txBitIdx <= '0;
                        r_txLine   <= r_txShift[0];
                        r_txState  <= S_DATA;
                    end else begin
                        r_txBaud <= r_txBaud + BW'(1);
                    end
                end
                S_DATA: begin
                    if (r_txBaud == BAUD_LAST) begin
                        r_txBaud <= '0;
                        if (r_txBitIdx == 3'd7) begin
                            r_txLine  <= 1'b1;
                            r_txState <= S_STOP;
                        end else begin
                            r_txBitIdx <= r_txBitIdx + 3'd1;
                            r_txShift  <= r_txShift >> 1;
                            r_txLine   <= r_txShift[1];
                        end
                    end else begin
                        r_txBaud <= r_txBaud + BW'(1);
                    end
                end
                default: begin
                    if (r_txBaud == BAUD_LAST) begin
                        r_txBaud  <= '0;
                        r_txState <= S_IDLE;
                    end else begin
                        r_txBaud <= r_txBaud + BW'(1);
                    end
                end
            endcase
        end
    end

    // The start bit is recognised one flop early (sync1) so every sample lands mid-bit on sync2.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rxSync1  <= 1'b1;
            r_rxSync2  <= 1'b1;
            r_rxState  <= S_IDLE;
            r_rxBaud   <= '0;
            r_rxBitIdx <= '0;
            r_rxShift  <= '0;
        end else begin
            r_rxSync1 <= w_rxIn;
            r_rxSync2 <= r_rxSync1;
            case (r_rxState)
                S_IDLE: begin
                    if (w_rxFall) begin
                        r_rxBaud  <= '0;
                        r_rxState <= S_START;
                    end
                end
                S_START: begin
                    if (r_rxBaud == BAUD_HALF) begin
                        r_rxBaud   <= '0;
                        r_rxBitIdx <= '0;
                        r_rxState  <= r_rxSync2 ? S_IDLE : S_DATA;
                    end else begin
                        r_rxBaud <= r_rxBaud + BW'(1);
                    end
                end
                S_DATA: begin
                    if (r_rxBaud == BAUD_LAST) begin
                        r_rxBaud  <= '0;
                        r_rxShift <= {r_rxSync2, r_rxShift[7:1]};
                        if (r_rxBitIdx == 3'd7) r_rxState <= S_STOP;
                        else                    r_rxBitIdx <= r_rxBitIdx + 3'd1;
                    end else begin
                        r_rxBaud <= r_rxBaud + BW'(1);
                    end
                end
                default: begin
                    if (r_rxBaud == BAUD_LAST) begin
                        r_rxBaud  <= '0;
                        r_rxState <= S_IDLE;
                    end else begin
                        r_rxBaud <= r_rxBaud + BW'(1);
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_controller.sv
// Directed bench for uart_controller with CLKS_PER_BIT=4; TX frames and RX reads are scored
// against queues of expected bytes. Define UART_LOOPBACK_EN to run the loopback sequence.
module tb_uart_controller;

    localparam int CPB = 4;
    localparam logic [31:0] ADDR_DATA   = 32'h0;
    localparam logic [31:0] ADDR_STATUS = 32'h4;
`ifdef UART_LOOPBACK_EN
    localparam logic [31:0] STATUS_IDLE = 32'h8000_0002;
`else
    localparam logic [31:0] STATUS_IDLE = 32'h0000_0002;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic txd;
    logic rxd   = 1'b1;

    int assertCount  = 0;
    int failCount    = 0;
    int txFrameCount = 0;
    bit monitorEn    = 1'b0;
    bit monitorBusy  = 1'b0;

    logic [7:0] txQ[$];
    logic [7:0] rxQ[$];

    uart_controller_if busIf();

    uart_controller #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (busIf),
        .txd   (txd),
        .rxd   (rxd)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic rd, input logic wr, input logic [31:0] addr,
                                 input logic [31:0] data, input logic [3:0] mask,
                                 output logic [31:0] rdData);
        @(negedge clk);
        busIf.bus_read    = rd;
        busIf.bus_write   = wr;
        busIf.bus_address = addr;
        busIf.bus_data_wr = data;
        busIf.bus_mask    = mask;
        #1 rdData = busIf.bus_data_rd;
    endtask

    task automatic busIdle();
        @(negedge clk);
        busIf.bus_read    = 1'b0;
        busIf.bus_write   = 1'b0;
        busIf.bus_address = 32'h0;
        busIf.bus_data_wr = 32'h0;
        busIf.bus_mask    = 4'h0;
    endtask

    task automatic readReg(input logic [31:0] addr, output logic [31:0] data);
        applyStimulus(1'b1, 1'b0, addr, 32'h0, 4'h0, data);
        busIdle();
    endtask

    task automatic writeReg(input logic [31:0] data, input logic [3:0] mask);
        logic [31:0] unusedRd;
        applyStimulus(1'b0, 1'b1, ADDR_DATA, data, mask, unusedRd);
        busIdle();
    endtask

    task automatic waitTxDrain(input int maxCycles);
        int n = 0;
        while ((txQ.size() != 0 || monitorBusy) && n < maxCycles) begin
            @(negedge clk);
            n++;
        end
        checkOutput("tx_drain_in_time", 32'(n < maxCycles), 32'd1);
    endtask

    task automatic sendFrame(input logic [7:0] b, input logic stopBit);
        @(negedge clk);
        rxd = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (CPB) @(negedge clk);
        end
        rxd = stopBit;
        repeat (CPB) @(negedge clk);
        rxd = 1'b1;
    endtask

    // Decodes each txd frame at mid-bit and scores it against the queue of written bytes.
    initial begin
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (monitorEn && txd === 1'b0) begin
                monitorBusy = 1'b1;
                repeat (2) @(negedge clk);
                checkOutput("tx_start_bit", 32'(txd), 32'd0);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    b[i] = txd;
                end
                repeat (CPB) @(negedge clk);
                checkOutput("tx_stop_bit", 32'(txd), 32'd1);
                txFrameCount++;
                if (txQ.size() == 0) begin
                    assertCount++;
                    failCount++;
                    $error("[TB] FAIL tx_unexpected_frame: observed 0x%02h expected no frame", b);
                end else begin
                    checkOutput("tx_byte", 32'(b), 32'(txQ.pop_front()));
                end
                monitorBusy = 1'b0;
            end
        end
    end

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] simulation time limit reached");
    end

    initial begin
        logic [31:0] rd;
        int          frameBase;
        logic        txdHigh;

        busIf.bus_read    = 1'b0;
        busIf.bus_write   = 1'b0;
        busIf.bus_address = 32'h0;
        busIf.bus_data_wr = 32'h0;
        busIf.bus_mask    = 4'h0;

        repeat (3) @(negedge clk);
        checkOutput("reset_txd", 32'(txd), 32'd1);
        checkOutput("reset_bus_data_rd", busIf.bus_data_rd, 32'h0);
        checkOutput("reset_bus_stall", 32'(busIf.bus_stall), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        readReg(ADDR_STATUS, rd);
        checkOutput("reset_status", rd, STATUS_IDLE);
        readReg(ADDR_DATA, rd);
        checkOutput("reset_data_empty", rd, 32'h0);
        readReg(32'h8, rd);
        checkOutput("unmapped_read", rd, 32'h0);

`ifdef UART_LOOPBACK_EN
        for (int k = 0; k < 2; k++) begin
            logic [7:0] v;
            v = (k == 0) ? 8'h5A : 8'hC3;
            rxQ.push_back(v);
            txdHigh = 1'b1;
            writeReg({24'h0, v}, 4'b1111);
            repeat (12 * CPB) begin
                @(negedge clk);
                if (txd !== 1'b1) txdHigh = 1'b0;
            end
            checkOutput("loop_txd_held_high", 32'(txdHigh), 32'd1);
            readReg(ADDR_DATA, rd);
            checkOutput("loop_data", rd, 32'(rxQ.pop_front()));
            readReg(ADDR_STATUS, rd);
            checkOutput("loop_status", rd, STATUS_IDLE);
        end
`else
        monitorEn = 1'b1;

        txQ.push_back(8'hA5);
        writeReg(32'h0000_00A5, 4'b1111);
        repeat (8) @(negedge clk);
        readReg(ADDR_STATUS, rd);
        checkOutput("tx_idle_during_frame", 32'(rd[1]), 32'd0);
        waitTxDrain(200);
        repeat (4) @(negedge clk);
        readReg(ADDR_STATUS, rd);
        checkOutput("tx_idle_after_frame", rd, STATUS_IDLE);

        writeReg(32'h0000_0077, 4'b1110);
        repeat (4) @(negedge clk);
        readReg(ADDR_STATUS, rd);
        checkOutput("masked_write_ignored", rd, STATUS_IDLE);

        // The first byte moves straight into the serializer, so 17 writes leave 16 queued.
        frameBase = txFrameCount;
        for (int i = 0; i < 17; i++) begin
            txQ.push_back(8'(i));
            applyStimulus(1'b0, 1'b1, ADDR_DATA, 32'(i), 4'b1111, rd);
        end
        busIdle();
        readReg(ADDR_STATUS, rd);
        checkOutput("tx_full_flag", 32'(rd[0]), 32'd1);
        writeReg(32'h0000_0011, 4'b1111);
        readReg(ADDR_STATUS, rd);
        checkOutput("tx_full_still_set", 32'(rd[0]), 32'd1);
        waitTxDrain(17 * 60);
        repeat (60) @(negedge clk);
        checkOutput("tx_frame_count", 32'(txFrameCount - frameBase), 32'd17);

        monitorEn = 1'b0;
        writeReg(32'h0000_0000, 4'b1111);
        repeat (12) @(negedge clk);
        checkOutput("txd_low_mid_frame", 32'(txd), 32'd0);
        rst_n = 1'b0;
        #1 checkOutput("txd_high_in_reset", 32'(txd), 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        txdHigh = 1'b1;
        repeat (50) begin
            @(negedge clk);
            if (txd !== 1'b1) txdHigh = 1'b0;
        end
        checkOutput("txd_high_after_reset", 32'(txdHigh), 32'd1);
        readReg(ADDR_STATUS, rd);
        checkOutput("status_after_reset", rd, STATUS_IDLE);
        monitorEn = 1'b1;

        rxQ.push_back(8'h3C);
        sendFrame(8'h3C, 1'b1);
        repeat (4) @(negedge clk);
        readReg(ADDR_STATUS, rd);
        checkOutput("rx_valid_after_frame", 32'(rd[2]), 32'd1);
        readReg(ADDR_DATA, rd);
        checkOutput("rx_data", rd, 32'(rxQ.pop_front()));
        readReg(ADDR_STATUS, rd);
        checkOutput("rx_valid_cleared", 32'(rd[2]), 32'd0);

        sendFrame(8'h00, 1'b0);
        repeat (4) @(negedge clk);
        readReg(ADDR_STATUS, rd);
        checkOutput("frame_err_set", rd, STATUS_IDLE | 32'h10);
        readReg(ADDR_STATUS, rd);
        checkOutput("frame_err_cleared", rd, STATUS_IDLE);

        for (int i = 0; i < 17; i++) begin
            if (i < 16) rxQ.push_back(8'(8'h40 + i));
            sendFrame(8'(8'h40 + i), 1'b1);
        end
        repeat (4) @(negedge clk);
        readReg(ADDR_STATUS, rd);
        checkOutput("overrun_set", rd, STATUS_IDLE | 32'h0C);
        while (rxQ.size() != 0) begin
            readReg(ADDR_DATA, rd);
            checkOutput("rx_fifo_data", rd, 32'(rxQ.pop_front()));
        end
        readReg(ADDR_STATUS, rd);
        checkOutput("rx_drained_overrun_cleared", rd, STATUS_IDLE);
        readReg(ADDR_DATA, rd);
        checkOutput("rx_empty_read", rd, 32'h0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
